// File: rtl/inst_issue_fifo_if.sv
// inst_issue_fifo_if: fetch push / issue pop bundle for the instruction queue.
interface inst_issue_fifo_if #(parameter int DEPTH = 16, parameter int AW = $clog2(DEPTH));
   logic          flush;
   logic          push_en1;
   logic          push_en2;
   logic [31:0]   push_inst1;
   logic [31:0]   push_pc1;
   logic [31:0]   push_inst2;
   logic [31:0]   push_pc2;
   logic          pop_master;
   logic          pop_slave;
   logic          out1_valid;
   logic [31:0]   out1_inst;
   logic [31:0]   out1_pc;
   logic          out2_valid;
   logic [31:0]   out2_inst;
   logic [31:0]   out2_pc;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   modport master (
      output flush, push_en1, push_en2, push_inst1, push_pc1, push_inst2, push_pc2,
             pop_master, pop_slave,
      input  out1_valid, out1_inst, out1_pc, out2_valid, out2_inst, out2_pc, full, empty, count
   );
   modport slave (
      input  flush, push_en1, push_en2, push_inst1, push_pc1, push_inst2, push_pc2,
             pop_master, pop_slave,
      output out1_valid, out1_inst, out1_pc, out2_valid, out2_inst, out2_pc, full, empty, count
   );
endinterface

// File: rtl/inst_issue_fifo.sv
// inst_issue_fifo: dual-write/dual-read instruction queue between fetch and issue.
module inst_issue_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input logic             clk,
   input logic             rst,
   inst_issue_fifo_if.slave q
);
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] head, tail, head1, tail1;
   logic [AW:0]   count;
   logic [1:0]    npush, npop;
   logic          v1, v2, full_i;
   assign head1  = head + AW'(1);
   assign tail1  = tail + AW'(1);
   assign v1     = count >= (AW+1)'(1);
   assign v2     = count >= (AW+1)'(2);
   assign full_i = count >= (AW+1)'(DEPTH-1);
   assign q.out1_valid = v1;
   assign q.out2_valid = v2;
   assign q.full       = full_i;
   assign q.empty      = count == '0;
   assign q.count      = count;
   assign {q.out1_pc, q.out1_inst} = v1 ? mem[head]  : 64'd0;
   assign {q.out2_pc, q.out2_inst} = v2 ? mem[head1] : 64'd0;
   // Second word only rides along with the first; a full queue drops both.
   assign npush = full_i ? 2'd0 : {q.push_en1 & q.push_en2, q.push_en1 & ~q.push_en2};
   assign npop  = !(v1 && q.pop_master) ? 2'd0 : (q.pop_slave && v2) ? 2'd2 : 2'd1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (q.flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(npop);
         tail  <= tail + AW'(npush);
         count <= count + (AW+1)'(npush) - (AW+1)'(npop);
      end
   always_ff @(posedge clk)
      if (!q.flush) begin
         if (npush != 2'd0) mem[tail]  <= {q.push_pc1, q.push_inst1};
         if (npush == 2'd2) mem[tail1] <= {q.push_pc2, q.push_inst2};
      end
endmodule

// File: tb/tb_inst_issue_fifo.sv
// tb_inst_issue_fifo: vector table plus queue scoreboard for inst_issue_fifo.
module tb_inst_issue_fifo;
   localparam int DEPTH = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   logic [63:0] sb [$];
   inst_issue_fifo_if #(.DEPTH(DEPTH)) bus ();
   inst_issue_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(bus));
   always #5 clk = ~clk;

   typedef struct {
      logic        fl, e1, e2;
      logic [31:0] i1, p1, i2, p2;
      logic        pm, ps;
      int          ecount;
      logic [31:0] eo1pc;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all();
      int n = sb.size();
      logic [63:0] x1, x2;
      x1 = n >= 1 ? sb[0] : 64'd0;
      x2 = n >= 2 ? sb[1] : 64'd0;
      chk("count", 32'(bus.count), 32'(n));
      chk("empty", 32'(bus.empty), 32'(n == 0));
      chk("full", 32'(bus.full), 32'(n >= DEPTH-1));
      chk("out1_valid", 32'(bus.out1_valid), 32'(n >= 1));
      chk("out1_inst", bus.out1_inst, x1[31:0]);
      chk("out1_pc", bus.out1_pc, x1[63:32]);
      chk("out2_valid", 32'(bus.out2_valid), 32'(n >= 2));
      chk("out2_inst", bus.out2_inst, x2[31:0]);
      chk("out2_pc", bus.out2_pc, x2[63:32]);
   endtask

   task automatic idle();
      bus.flush = 0; bus.push_en1 = 0; bus.push_en2 = 0;
      bus.push_inst1 = 0; bus.push_pc1 = 0; bus.push_inst2 = 0; bus.push_pc2 = 0;
      bus.pop_master = 0; bus.pop_slave = 0;
   endtask

   // Drives one cycle, updates the scoreboard from pre-edge occupancy, checks after the edge.
   task automatic step(input logic fl, e1, e2, input logic [31:0] i1, p1, i2, p2,
                       input logic pm, ps);
      int n, np;
      bus.flush = fl; bus.push_en1 = e1; bus.push_en2 = e2;
      bus.push_inst1 = i1; bus.push_pc1 = p1; bus.push_inst2 = i2; bus.push_pc2 = p2;
      bus.pop_master = pm; bus.pop_slave = ps;
      n = sb.size();
      if (fl) sb.delete();
      else begin
         np = (pm && n >= 1) ? ((ps && n >= 2) ? 2 : 1) : 0;
         repeat (np) void'(sb.pop_front());
         if (n < DEPTH-1 && e1) begin
            sb.push_back({p1, i1});
            if (e2) sb.push_back({p2, i2});
         end
      end
      @(posedge clk);
      #1;
      idle();
      check_all();
   endtask

   initial begin
      logic [31:0] pc;
      idle();
      tbl[0] = '{0, 1, 1, 32'h00000013, 32'hBFC00000, 32'h24020001, 32'hBFC00004, 0, 0, 2, 32'hBFC00000};
      tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hBFC00004};
      tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0};
      tbl[3] = '{0, 0, 1, 0, 0, 32'hDEAD, 32'h500, 0, 0, 0, 32'h0};
      tbl[4] = '{0, 1, 0, 32'h11, 32'h200, 32'h99, 32'h600, 0, 0, 1, 32'h200};
      tbl[5] = '{0, 1, 1, 32'h22, 32'h204, 32'h33, 32'h208, 1, 0, 2, 32'h204};
      tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0};
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      check_all();
      for (int k = 0; k < 7; k++) begin
         step(tbl[k].fl, tbl[k].e1, tbl[k].e2, tbl[k].i1, tbl[k].p1, tbl[k].i2, tbl[k].p2,
              tbl[k].pm, tbl[k].ps);
         chk($sformatf("vec%0d_count", k), 32'(bus.count), 32'(tbl[k].ecount));
         chk($sformatf("vec%0d_out1_pc", k), bus.out1_pc, tbl[k].eo1pc);
      end
      // full boundary
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      pc = 32'h8000;
      for (int k = 0; k < 7; k++) begin
         step(0, 1, 1, pc ^ 32'h55, pc, pc ^ 32'h59, pc + 4, 0, 0);
         pc += 8;
      end
      step(0, 1, 0, pc ^ 32'h55, pc, 0, 0, 0, 0);
      pc += 4;
      chk("full_count15", 32'(bus.count), 32'd15);
      chk("full_flag", 32'(bus.full), 32'd1);
      step(0, 1, 1, 32'hBAD1, 32'hBAD0, 32'hBAD3, 32'hBAD2, 1, 0);
      chk("full_blocked_count", 32'(bus.count), 32'd14);
      for (int k = 0; k < 7; k++) step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 1, 0, 32'h7777, 32'h7770, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      // wrap-around streaming
      pc = 32'h1000;
      for (int c = 0; c < 20; c++) begin
         step(0, 1, 1, ~pc, pc, ~(pc + 4), pc + 4, 1, 1);
         pc += 8;
         if (c > 0) chk("wrap_count", 32'(bus.count), 32'd2);
      end
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      // flush priority
      step(0, 1, 1, 32'hA1, 32'h2000, 32'hA2, 32'h2004, 0, 0);
      step(0, 1, 1, 32'hA3, 32'h2008, 32'hA4, 32'h200C, 0, 0);
      step(0, 1, 0, 32'hA5, 32'h2010, 0, 0, 0, 0);
      chk("flush_pre_count", 32'(bus.count), 32'd5);
      step(1, 1, 1, 32'hB1, 32'h2100, 32'hB2, 32'h2104, 1, 1);
      chk("flush_count", 32'(bus.count), 32'd0);
      chk("flush_empty", 32'(bus.empty), 32'd1);
      step(0, 1, 0, 32'hC1, 32'h3000, 0, 0, 0, 0);
      chk("post_flush_pc", bus.out1_pc, 32'h3000);
      // asynchronous reset mid-cycle
      step(0, 1, 1, 32'hD1, 32'h4000, 32'hD2, 32'h4004, 0, 0);
      #2;
      rst = 1;
      #1;
      chk("async_rst_count", 32'(bus.count), 32'd0);
      chk("async_rst_valid", 32'(bus.out1_valid), 32'd0);
      chk("async_rst_empty", 32'(bus.empty), 32'd1);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 0;
      check_all();
      step(0, 1, 0, 32'hE1, 32'h5000, 0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
